sr_register_bank: RTL and testbench
===================================

Name: sr_register_bank

Overview:
Parametrised bank of N_CH edge-triggered SR storage channels. The block is the registered, multi-channel successor of the single SR flip-flop. It adds a runtime-selectable policy for S=R=1, global enable, per-channel edge-event pulses and conflict bookkeeping (sticky flags plus a saturating counter). It sits between raw set/clear request sources (interrupt/status lines) and consumers needing clean registered state.

Parameters:
N_CH, 8, number of independent SR channels (>=1)
RESET_VAL, 0 (N_CH bits), per-channel value of q after reset
CNT_W, 8, width of conflict cycle counter (>=1)

Ports:
clk  input  1  rising-edge clock; all state updates here only
reset  input  1  reset, synchronous, active-high
en  input  1  global update enable
mode  input  2  conflict policy: 0 HOLD, 1 SET_DOM, 2 RST_DOM, 3 TOGGLE
s  input  N_CH  per-channel set request
r  input  N_CH  per-channel reset request
conflict_clr  input  1  clears conflict_flag and conflict_cnt
q  output  N_CH  registered channel state
qb  output  N_CH  always bitwise ~q (combinational from q)
rise  output  N_CH  one-cycle pulse, channel q went 0->1 at last edge
fall  output  N_CH  one-cycle pulse, channel q went 1->0 at last edge
conflict_flag  output  N_CH  sticky: channel saw s=r=1 while en=1
conflict_cnt  output  CNT_W  cycles with any recorded conflict, saturating

Behaviour:
- Reset (sampled at posedge, highest priority over en, mode, conflict_clr): q=RESET_VAL, qb=~RESET_VAL, rise=0, fall=0, conflict_flag=0, conflict_cnt=0.
- q is never X. qb is never X and is never stale relative to q.
- en=0: q holds, rise=fall=0 next cycle, no conflicts recorded. conflict_clr still acts.
- en=1, per channel i at each posedge, next q[i]:
  - s=0 r=0 -> hold
  - s=0 r=1 -> 0
  - s=1 r=0 -> 1
  - s=1 r=1 -> by mode: HOLD keeps q, SET_DOM ->1, RST_DOM ->0, TOGGLE ->~q
- mode is sampled each edge. A mid-stream change takes effect at the next edge; no pipelining.
- Latency: one clock from s/r to q.
- rise/fall are registered at the same edge as q: rise[i]=new q & ~old q, fall[i]=~new q & old q. They are high exactly one cycle, coincident with the new q. A held value gives 0. TOGGLE with continuous s=r=1 pulses rise/fall on alternating cycles.
- Conflict event for channel i is s[i]&r[i]&en. It sets conflict_flag[i] regardless of mode.
- conflict_cnt increments by 1 per cycle in which any channel has a conflict event, not per channel. It saturates at 2^CNT_W-1 and does not wrap.
- conflict_clr=1 zeroes flags and count at the edge. If a conflict event occurs in the same cycle, the new event wins: the affected flags are 1 and the count is 1.
- Reset asserted mid-operation discards all state in that cycle. Pending s/r in the reset cycle are ignored.

Decomposition:
- Package sr_bank_pkg: mode localparams/enum (MODE_HOLD=0, MODE_SET_DOM=1, MODE_RST_DOM=2, MODE_TOGGLE=3) and the next-state function for one channel.
- Sub-module sr_cell: one channel holding q, rise, fall, conflict_flag. It is instantiated N_CH times via generate.
- Top level contains only the OR-reduction of conflict events and the saturating counter.

Test Plan:
- N_CH=4, RESET_VAL=4'b1010: assert reset 2 cycles with s=r=4'hF -> q=1010, qb=0101, rise=fall=0, flags=0, cnt=0. Release reset, en=1, s=0001 r=1000 -> next cycle q=0011, rise=0001, fall=1000.
- Policy sweep: q=0000, s=r=4'hF for one cycle in each mode. HOLD -> q=0000. SET_DOM -> q=1111, rise=1111. RST_DOM -> q=0000, fall=1111. TOGGLE held 3 cycles -> q=1111, 0000, 1111 with alternating rise/fall.
- en gating: en=0, s=4'hF -> q unchanged, rise=0, cnt unchanged. Same stimulus with en=1 -> q=1111 after one edge.
- Conflict bookkeeping: s=r=0011 for 3 cycles -> flags=0011, cnt=3. conflict_clr with no conflict -> flags=0, cnt=0. conflict_clr plus s=r=0100 in the same cycle -> flags=0100, cnt=1.
- Saturation, CNT_W=2: 6 consecutive conflict cycles -> cnt goes 1,2,3,3,3,3 and never wraps to 0.
- Reset mid-operation: q=1111, flags set, cnt=2, assert reset with s=0001 -> next cycle all outputs at reset values. First post-reset edge applies s/r normally.

Source files
------------

// File: rtl/sr_bank_pkg.sv
// Shared definitions for the SR register bank.
//   sr_mode_e : conflict policy applied when s = r = 1
//   sr_next() : next value of one channel for a given request pair and policy
package sr_bank_pkg;

  typedef enum logic [1:0] {
    MODE_HOLD    = 2'd0,
    MODE_SET_DOM = 2'd1,
    MODE_RST_DOM = 2'd2,
    MODE_TOGGLE  = 2'd3
  } sr_mode_e;

  // Next-state rule for one channel while updates are enabled.
  function automatic logic sr_next(input logic q, input logic s, input logic r,
                                   input sr_mode_e mode);
    logic nq;
    nq = q;
    case ({s, r})
      2'b00: nq = q;
      2'b01: nq = 1'b0;
      2'b10: nq = 1'b1;
      default: begin
        case (mode)
          MODE_HOLD:    nq = q;
          MODE_SET_DOM: nq = 1'b1;
          MODE_RST_DOM: nq = 1'b0;
          default:      nq = ~q;
        endcase
      end
    endcase
    return nq;
  endfunction

endpackage

// File: rtl/sr_cell.sv
// One SR storage channel with edge-event pulses and a sticky conflict flag.
// Ports:
//   clk, reset         : clock, synchronous active-high reset
//   en, mode           : global update enable, conflict policy
//   s, r               : set / reset requests for this channel
//   conflict_clr       : clears the sticky conflict flag
//   q                  : registered state
//   rise, fall         : one-cycle pulses coincident with a new q value
//   conflict_flag      : sticky record of s = r = 1 while enabled
//   conflict_event     : combinational s & r & en, used by the bank counter
module sr_cell
  import sr_bank_pkg::*;
#(
  parameter logic RESET_BIT = 1'b0
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       en,
  input  logic [1:0] mode,
  input  logic       s,
  input  logic       r,
  input  logic       conflict_clr,
  output logic       q,
  output logic       rise,
  output logic       fall,
  output logic       conflict_flag,
  output logic       conflict_event
);

  logic q_reg;
  logic q_next;
  logic rise_reg;
  logic fall_reg;
  logic flag_reg;

  assign q_next         = sr_next(q_reg, s, r, sr_mode_e'(mode));
  assign conflict_event = s & r & en;

  always_ff @(posedge clk) begin
    if (reset) begin
      q_reg    <= RESET_BIT;
      rise_reg <= 1'b0;
      fall_reg <= 1'b0;
      flag_reg <= 1'b0;
    end else begin
      if (en) begin
        q_reg    <= q_next;
        rise_reg <= q_next & ~q_reg;
        fall_reg <= ~q_next & q_reg;
      end else begin
        rise_reg <= 1'b0;
        fall_reg <= 1'b0;
      end
      // A fresh conflict outranks a simultaneous clear.
      if (conflict_event) begin
        flag_reg <= 1'b1;
      end else if (conflict_clr) begin
        flag_reg <= 1'b0;
      end
    end
  end

  assign q             = q_reg;
  assign rise          = rise_reg;
  assign fall          = fall_reg;
  assign conflict_flag = flag_reg;

endmodule

// File: rtl/sr_register_bank.sv
// Bank of N_CH registered SR channels with a shared conflict policy.
// Ports:
//   clk, reset         : clock, synchronous active-high reset
//   en, mode           : global update enable, conflict policy (0 HOLD,
//                        1 SET_DOM, 2 RST_DOM, 3 TOGGLE)
//   s, r               : per-channel set / reset requests
//   conflict_clr       : clears conflict flags and counter
//   q, qb              : registered state and its complement
//   rise, fall         : per-channel edge pulses
//   conflict_flag      : per-channel sticky conflict flags
//   conflict_cnt       : saturating count of cycles with any conflict
module sr_register_bank
  import sr_bank_pkg::*;
#(
  parameter int              N_CH      = 8,
  parameter logic [N_CH-1:0] RESET_VAL = '0,
  parameter int              CNT_W     = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic [1:0]       mode,
  input  logic [N_CH-1:0]  s,
  input  logic [N_CH-1:0]  r,
  input  logic             conflict_clr,
  output logic [N_CH-1:0]  q,
  output logic [N_CH-1:0]  qb,
  output logic [N_CH-1:0]  rise,
  output logic [N_CH-1:0]  fall,
  output logic [N_CH-1:0]  conflict_flag,
  output logic [CNT_W-1:0] conflict_cnt
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic [N_CH-1:0]  conflict_event;
  logic             any_event;
  logic [CNT_W-1:0] cnt_reg;
  logic [CNT_W-1:0] cnt_next;

  for (genvar gi = 0; gi < N_CH; gi++) begin : g_cell
    sr_cell #(
      .RESET_BIT(RESET_VAL[gi])
    ) u_cell (
      .clk           (clk),
      .reset         (reset),
      .en            (en),
      .mode          (mode),
      .s             (s[gi]),
      .r             (r[gi]),
      .conflict_clr  (conflict_clr),
      .q             (q[gi]),
      .rise          (rise[gi]),
      .fall          (fall[gi]),
      .conflict_flag (conflict_flag[gi]),
      .conflict_event(conflict_event[gi])
    );
  end

  // The counter tracks cycles, not channels, so one OR covers the bank.
  assign any_event = |conflict_event;

  always_comb begin
    cnt_next = cnt_reg;
    if (any_event) begin
      if (conflict_clr) begin
        cnt_next = {{(CNT_W-1){1'b0}}, 1'b1};
      end else if (cnt_reg != CNT_MAX) begin
        cnt_next = cnt_reg + 1'b1;
      end
    end else if (conflict_clr) begin
      cnt_next = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_reg <= '0;
    end else begin
      cnt_reg <= cnt_next;
    end
  end

  assign qb           = ~q;
  assign conflict_cnt = cnt_reg;

endmodule

// File: tb/tb_sr_register_bank.sv
// Randomised and directed bench for sr_register_bank (N_CH=4,
// RESET_VAL=4'b1010, CNT_W=2) against a behavioural reference model.
module tb_sr_register_bank;

  localparam int N = 4;
  localparam logic [N-1:0] RV = 4'b1010;
  localparam int CW = 2;
  localparam int CMAX = (1 << CW) - 1;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          en = 1'b0;
  logic [1:0]    mode = 2'd0;
  logic [N-1:0]  s = '1;
  logic [N-1:0]  r = '1;
  logic          conflict_clr = 1'b0;
  logic [N-1:0]  q, qb, rise, fall, conflict_flag;
  logic [CW-1:0] conflict_cnt;

  int n_cmp = 0;
  int n_bad = 0;

  // reference model state
  logic [N-1:0] m_q, m_rise, m_fall, m_flag;
  int           m_cnt;

  always #5 clk = ~clk;

  sr_register_bank #(.N_CH(N), .RESET_VAL(RV), .CNT_W(CW)) dut (
    .clk(clk), .reset(reset), .en(en), .mode(mode), .s(s), .r(r),
    .conflict_clr(conflict_clr), .q(q), .qb(qb), .rise(rise), .fall(fall),
    .conflict_flag(conflict_flag), .conflict_cnt(conflict_cnt)
  );

  function automatic logic [5*N+CW-1:0] obs();
    return {q, qb, rise, fall, conflict_flag, conflict_cnt};
  endfunction

  function automatic logic [5*N+CW-1:0] expv();
    logic [CW-1:0] c;
    c = CW'(m_cnt);
    return {m_q, ~m_q, m_rise, m_fall, m_flag, c};
  endfunction

  // Drive one cycle of stimulus, advance the model at the edge, settle.
  task automatic tick(input logic rst, input logic e, input logic [1:0] md,
                      input logic [N-1:0] sv, input logic [N-1:0] rv,
                      input logic clr);
    logic [N-1:0] old_q, ev;
    reset = rst; en = e; mode = md; s = sv; r = rv; conflict_clr = clr;
    @(posedge clk);
    if (rst) begin
      m_q = RV; m_rise = '0; m_fall = '0; m_flag = '0; m_cnt = 0;
    end else begin
      old_q = m_q;
      if (e) begin
        for (int i = 0; i < N; i++) begin
          if (sv[i] && !rv[i])      m_q[i] = 1'b1;
          else if (!sv[i] && rv[i]) m_q[i] = 1'b0;
          else if (sv[i] && rv[i]) begin
            if (md == 2'd1)      m_q[i] = 1'b1;
            else if (md == 2'd2) m_q[i] = 1'b0;
            else if (md == 2'd3) m_q[i] = ~old_q[i];
          end
        end
        m_rise = m_q & ~old_q;
        m_fall = ~m_q & old_q;
        ev = sv & rv;
      end else begin
        m_rise = '0; m_fall = '0; ev = '0;
      end
      if (clr) begin
        m_flag = '0;
        m_cnt  = 0;
      end
      m_flag = m_flag | ev;
      if (ev != 0) m_cnt = (m_cnt < CMAX) ? m_cnt + 1 : CMAX;
    end
    #1;
  endtask

  task automatic test_reset();
    tick(1, 1, 2'd3, 4'hF, 4'hF, 0);
    tick(1, 1, 2'd3, 4'hF, 4'hF, 0);
    n_cmp++;
    if (obs() !== {4'b1010, 4'b0101, 4'b0, 4'b0, 4'b0, 2'd0}) begin
      n_bad++; $display("FAIL reset_state got=%h exp=%h", obs(),
                        {4'b1010, 4'b0101, 4'b0, 4'b0, 4'b0, 2'd0});
    end
    tick(0, 1, 2'd0, 4'b0001, 4'b1000, 0);
    n_cmp++;
    if ({q, rise, fall} !== {4'b0011, 4'b0001, 4'b1000}) begin
      n_bad++; $display("FAIL first_update got q=%b rise=%b fall=%b exp 0011/0001/1000",
                        q, rise, fall);
    end
    $display("test_reset q=%b qb=%b", q, qb);
  endtask

  task automatic test_policy();
    logic [N-1:0] tq [3];
    tq[0] = 4'hF; tq[1] = 4'h0; tq[2] = 4'hF;
    tick(0, 1, 2'd0, 4'h0, 4'hF, 0);
    tick(0, 1, 2'd0, 4'hF, 4'hF, 0);
    n_cmp++;
    if (q !== 4'h0 || obs() !== expv()) begin
      n_bad++; $display("FAIL policy_hold got=%h exp=%h", obs(), expv());
    end
    tick(0, 1, 2'd1, 4'hF, 4'hF, 0);
    n_cmp++;
    if (q !== 4'hF || rise !== 4'hF || obs() !== expv()) begin
      n_bad++; $display("FAIL policy_set_dom got=%h exp=%h", obs(), expv());
    end
    tick(0, 1, 2'd2, 4'hF, 4'hF, 0);
    n_cmp++;
    if (q !== 4'h0 || fall !== 4'hF || obs() !== expv()) begin
      n_bad++; $display("FAIL policy_rst_dom got=%h exp=%h", obs(), expv());
    end
    for (int k = 0; k < 3; k++) begin
      tick(0, 1, 2'd3, 4'hF, 4'hF, 0);
      n_cmp++;
      if (q !== tq[k] || rise !== tq[k] || fall !== ~tq[k] || obs() !== expv()) begin
        n_bad++; $display("FAIL policy_toggle_%0d got=%h exp=%h", k, obs(), expv());
      end
    end
    $display("test_policy q=%b cnt=%0d", q, conflict_cnt);
  endtask

  task automatic test_en_gating();
    logic [N-1:0] q0;
    logic [CW-1:0] c0;
    tick(0, 1, 2'd0, 4'h0, 4'hF, 1);
    q0 = q; c0 = conflict_cnt;
    tick(0, 0, 2'd0, 4'hF, 4'h0, 0);
    n_cmp++;
    if (q !== q0 || rise !== 4'h0 || conflict_cnt !== c0 || obs() !== expv()) begin
      n_bad++; $display("FAIL en_low got=%h exp=%h", obs(), expv());
    end
    tick(0, 1, 2'd0, 4'hF, 4'h0, 0);
    n_cmp++;
    if (q !== 4'hF || obs() !== expv()) begin
      n_bad++; $display("FAIL en_high got=%h exp=%h", obs(), expv());
    end
    $display("test_en_gating q=%b", q);
  endtask

  task automatic test_conflict();
    tick(0, 1, 2'd0, 4'h0, 4'h0, 1);
    for (int k = 0; k < 3; k++) tick(0, 1, 2'd0, 4'b0011, 4'b0011, 0);
    n_cmp++;
    if (conflict_flag !== 4'b0011 || conflict_cnt !== 2'd3 || obs() !== expv()) begin
      n_bad++; $display("FAIL conflict_accum got=%h exp=%h", obs(), expv());
    end
    tick(0, 1, 2'd0, 4'h0, 4'h0, 1);
    n_cmp++;
    if (conflict_flag !== 4'h0 || conflict_cnt !== 2'd0 || obs() !== expv()) begin
      n_bad++; $display("FAIL conflict_clear got=%h exp=%h", obs(), expv());
    end
    tick(0, 1, 2'd0, 4'b0100, 4'b0100, 1);
    n_cmp++;
    if (conflict_flag !== 4'b0100 || conflict_cnt !== 2'd1 || obs() !== expv()) begin
      n_bad++; $display("FAIL conflict_clr_vs_event got=%h exp=%h", obs(), expv());
    end
    $display("test_conflict flags=%b cnt=%0d", conflict_flag, conflict_cnt);
  endtask

  task automatic test_saturation();
    int seq [6] = '{1, 2, 3, 3, 3, 3};
    tick(0, 1, 2'd0, 4'h0, 4'h0, 1);
    for (int k = 0; k < 6; k++) begin
      tick(0, 1, 2'(k % 4), 4'b1001, 4'b1001, 0);
      n_cmp++;
      if (int'(conflict_cnt) != seq[k] || obs() !== expv()) begin
        n_bad++; $display("FAIL saturate_%0d got cnt=%0d exp=%0d", k, conflict_cnt, seq[k]);
      end
    end
    $display("test_saturation cnt=%0d", conflict_cnt);
  endtask

  task automatic test_reset_mid();
    tick(0, 1, 2'd0, 4'hF, 4'h0, 1);
    tick(0, 1, 2'd1, 4'hF, 4'hF, 0);
    tick(0, 1, 2'd1, 4'hF, 4'hF, 0);
    n_cmp++;
    if (q !== 4'hF || conflict_cnt !== 2'd2 || conflict_flag !== 4'hF) begin
      n_bad++; $display("FAIL reset_mid_setup got=%h exp=%h", obs(), expv());
    end
    tick(1, 1, 2'd0, 4'b0001, 4'h0, 0);
    n_cmp++;
    if (obs() !== {4'b1010, 4'b0101, 4'b0, 4'b0, 4'b0, 2'd0}) begin
      n_bad++; $display("FAIL reset_mid got=%h exp=%h", obs(),
                        {4'b1010, 4'b0101, 4'b0, 4'b0, 4'b0, 2'd0});
    end
    tick(0, 1, 2'd0, 4'b0001, 4'h0, 0);
    n_cmp++;
    if (q !== 4'b1011 || rise !== 4'b0001 || obs() !== expv()) begin
      n_bad++; $display("FAIL post_reset got=%h exp=%h", obs(), expv());
    end
    $display("test_reset_mid q=%b", q);
  endtask

  task automatic test_random();
    int nbad0;
    nbad0 = n_bad;
    for (int k = 0; k < 300; k++) begin
      tick(($urandom_range(0, 40) == 0), ($urandom_range(0, 3) != 0),
           2'($urandom_range(0, 3)), 4'($urandom), 4'($urandom),
           ($urandom_range(0, 7) == 0));
      n_cmp++;
      if (obs() !== expv()) begin
        n_bad++; $display("FAIL random_%0d got=%h exp=%h", k, obs(), expv());
      end
    end
    $display("test_random cycles=300 new_bad=%0d", n_bad - nbad0);
  endtask

  initial begin
    test_reset();
    test_policy();
    test_en_gating();
    test_conflict();
    test_saturation();
    test_reset_mid();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
